// File: rtl/vred_chunk_sequencer_if.sv
// rtl/vred_chunk_sequencer_if.sv - request, VRF read and framed chunk stream signals of the reduction front end
interface vred_chunk_sequencer_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int VL_WIDTH    = 11,
    parameter int OPSEL_WIDTH = 2,
    parameter int SEW_WIDTH   = 2
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_WIDTH-1:0]  req_base;
    logic [VL_WIDTH-1:0]    req_vl;
    logic [SEW_WIDTH-1:0]   req_sew;
    logic [OPSEL_WIDTH-1:0] req_opSel;
    logic                   rd_en;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [DATA_WIDTH-1:0]  out_vec;
    logic                   out_valid;
    logic                   out_start;
    logic                   out_end;
    logic [OPSEL_WIDTH-1:0] out_opSel;
    logic [SEW_WIDTH-1:0]   out_sew;
    logic                   done;

    modport master (
        output req_valid, req_base, req_vl, req_sew, req_opSel, rd_data,
        input  req_ready, rd_en, rd_addr, out_vec, out_valid, out_start, out_end,
               out_opSel, out_sew, done
    );

    modport slave (
        input  req_valid, req_base, req_vl, req_sew, req_opSel, rd_data,
        output req_ready, rd_en, rd_addr, out_vec, out_valid, out_start, out_end,
               out_opSel, out_sew, done
    );
endinterface

// File: rtl/vred_chunk_sequencer.sv
// rtl/vred_chunk_sequencer.sv - reads a vector from the VRF chunk by chunk and emits a framed, tail-masked stream
module vred_chunk_sequencer #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int VL_WIDTH    = 11,
    parameter int OPSEL_WIDTH = 2,
    parameter int SEW_WIDTH   = 2
) (
    input logic                  clk,
    input logic                  rst,
    vred_chunk_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                 state;
    logic                   req_ready_q;
    logic                   rd_en_q;
    logic [ADDR_WIDTH-1:0]  rd_addr_q;
    logic [VL_WIDTH-1:0]    issue_idx;
    logic [VL_WIDTH-1:0]    last_idx;
    logic [3:0]             keep_bytes;
    logic [SEW_WIDTH-1:0]   sew_q;
    logic [OPSEL_WIDTH-1:0] op_q;
    logic                   sb_valid, sb_start, sb_end;
    logic [DATA_WIDTH-1:0]  out_vec_q;
    logic                   out_valid_q, out_start_q, out_end_q, done_q;
    logic [OPSEL_WIDTH-1:0] out_opsel_q;
    logic [SEW_WIDTH-1:0]   out_sew_q;

    logic [3:0]             req_epc;
    logic [VL_WIDTH:0]      req_chunks;
    logic [VL_WIDTH-1:0]    req_vl_m1;
    logic [2:0]             req_tail_pos;
    logic [3:0]             req_keep;
    logic [7:0]             fill_byte;
    logic [DATA_WIDTH-1:0]  masked;

    // The final chunk keeps only its first keep_bytes bytes; that count is fixed per request.
    always_comb begin
        req_epc      = 4'd8 >> bus.req_sew;
        req_chunks   = ({1'b0, bus.req_vl} + {{(VL_WIDTH-3){1'b0}}, req_epc} - 1'b1) >> (2'd3 - bus.req_sew);
        req_vl_m1    = bus.req_vl - 1'b1;
        req_tail_pos = req_vl_m1[2:0] & 3'(req_epc - 4'd1);
        req_keep     = 4'(({1'b0, req_tail_pos} + 4'd1) << bus.req_sew);
    end

    assign fill_byte = (op_q == 2'b01) ? 8'hFF : 8'h00;

    always_comb begin
        masked = bus.rd_data;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (sb_end && (4'(b) >= keep_bytes))
                masked[8*b +: 8] = fill_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            req_ready_q <= 1'b1;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            issue_idx   <= '0;
            last_idx    <= '0;
            keep_bytes  <= '0;
            sew_q       <= '0;
            op_q        <= '0;
            sb_valid    <= 1'b0;
            sb_start    <= 1'b0;
            sb_end      <= 1'b0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            out_end_q   <= 1'b0;
            out_opsel_q <= '0;
            out_sew_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            // Sideband flags follow each read by one cycle so they line up with rd_data.
            sb_valid    <= rd_en_q;
            sb_start    <= rd_en_q && (issue_idx == '0);
            sb_end      <= rd_en_q && (issue_idx == last_idx);
            out_valid_q <= sb_valid;
            out_start_q <= sb_start;
            out_end_q   <= sb_end;
            out_vec_q   <= sb_valid ? masked : '0;
            out_opsel_q <= sb_valid ? op_q : '0;
            out_sew_q   <= sb_valid ? sew_q : '0;
            done_q      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        sew_q       <= bus.req_sew;
                        op_q        <= bus.req_opSel;
                        last_idx    <= VL_WIDTH'(req_chunks - 1'b1);
                        keep_bytes  <= req_keep;
                        issue_idx   <= '0;
                        req_ready_q <= 1'b0;
                        if (bus.req_vl == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state     <= S_ISSUE;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= bus.req_base;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue_idx == last_idx) begin
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        state     <= S_DRAIN;
                    end else begin
                        issue_idx <= issue_idx + 1'b1;
                        rd_addr_q <= rd_addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_valid_q && out_end_q) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_vec   = out_vec_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_start = out_start_q;
    assign bus.out_end   = out_end_q;
    assign bus.out_opSel = out_opsel_q;
    assign bus.out_sew   = out_sew_q;
    assign bus.done      = done_q;
endmodule
